// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned MULTU/DIVU sequencer that borrows the EX-stage ALU for one
// add/subtract per cycle, 32 iterations, results in HI/LO.
module alu_muldiv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        alu_own,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_signal,
  input  logic [31:0] alu_result,
  output logic        busy,
  output logic        done,
  output logic        div0,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W    = 32;
  localparam int unsigned ITER = 32;
  localparam int unsigned CW   = 5;
  localparam logic [2:0]  ALU_ADD = 3'b010;
  localparam logic [2:0]  ALU_SUB = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  m_q, m_d;
  logic          op_q, op_d;
  logic          div0_q, div0_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          own_q, own_d;

  logic [W-1:0]  rem_shift;
  logic          add_c;
  logic          sub_nb;

  // ALU drive: purely from registers so the borrowed ALU sees operands immediately.
  always_comb begin
    rem_shift  = {hi_q[W-2:0], lo_q[W-1]};
    alu_a      = '0;
    alu_b      = '0;
    alu_signal = ALU_ADD;
    if (state_q == S_RUN) begin
      alu_b = m_q;
      if (op_q) begin
        alu_a      = rem_shift;
        alu_signal = ALU_SUB;
      end else begin
        alu_a = hi_q;
      end
    end
  end

  // The ALU exports no carry, so recover carry / no-borrow from the MSBs.
  always_comb begin
    add_c  = (alu_a[W-1] & alu_b[W-1]) |
             ((alu_a[W-1] ^ alu_b[W-1]) & ~alu_result[W-1]);
    sub_nb = (alu_a[W-1] & ~alu_b[W-1]) |
             (~(alu_a[W-1] ^ alu_b[W-1]) & ~alu_result[W-1]);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    m_d     = m_q;
    op_d    = op_q;
    div0_d  = div0_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = op;
          cnt_d  = '0;
          div0_d = 1'b0;
          hi_d   = '0;
          state_d = S_RUN;
          if (!op) begin
            m_d  = src_a;
            lo_d = src_b;
          end else begin
            m_d  = src_b;
            lo_d = src_a;
            if (src_b == '0) begin
              hi_d    = src_a;
              lo_d    = '1;
              div0_d  = 1'b1;
              state_d = S_DONE;
            end
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (!op_q) begin
          // Shift-add: the 65-bit {carry, sum, LO} shifts right by one.
          if (lo_q[0]) begin
            hi_d = {add_c, alu_result[W-1:1]};
            lo_d = {alu_result[0], lo_q[W-1:1]};
          end else begin
            hi_d = {1'b0, hi_q[W-1:1]};
            lo_d = {hi_q[0], lo_q[W-1:1]};
          end
        end else begin
          // Restoring divide: a shifted-out MSB means the remainder already exceeds M.
          if (hi_q[W-1] | sub_nb) begin
            hi_d = alu_result;
            lo_d = {lo_q[W-2:0], 1'b1};
          end else begin
            hi_d = rem_shift;
            lo_d = {lo_q[W-2:0], 1'b0};
          end
        end
        if (cnt_q == CW'(ITER - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    own_d  = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      m_q     <= '0;
      op_q    <= 1'b0;
      div0_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      own_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      m_q     <= m_d;
      op_q    <= op_d;
      div0_q  <= div0_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      own_q   <= own_d;
    end
  end

  assign alu_own = own_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign div0    = div0_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: emulates the EX ALU and checks HI/LO,
// latency and control outputs against plain-arithmetic expectations.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        alu_own;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_signal;
  logic [31:0] alu_result;
  logic        busy;
  logic        done;
  logic        div0;
  logic [31:0] hi;
  logic [31:0] lo;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  alu_muldiv_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .alu_own    (alu_own),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_signal (alu_signal),
    .alu_result (alu_result),
    .busy       (busy),
    .done       (done),
    .div0       (div0),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  // EX-stage ALU stand-in: 010 adds, 011 subtracts.
  always_comb begin
    if (alu_signal == 3'b011) alu_result = alu_a - alu_b;
    else                      alu_result = alu_a + alu_b;
  end

  // Reference results from plain arithmetic.
  function automatic logic [63:0] ref_hilo(input logic o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (!o) begin
      p = 64'(a) * 64'(b);
    end else if (b == 32'd0) begin
      p = {a, 32'hFFFF_FFFF};
    end else begin
      p = {a % b, a / b};
    end
    return p;
  endfunction

  // Launch one operation and observe it until done (bounded); optionally spray starts.
  task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b, input bit noise,
                        output int lat, output int own_cyc, output logic [2:0] run_sig,
                        output logic post_done, output logic post_busy);
    bit seen;
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(posedge clk); #1;
    start = 1'b0; src_a = $urandom; src_b = $urandom; op = $urandom_range(0, 1);
    lat = 0; own_cyc = 0; seen = 0; run_sig = 3'b000;
    for (int k = 0; k < 100; k++) begin
      if (busy) lat++;
      if (alu_own) begin
        own_cyc++;
        run_sig = alu_signal;
      end
      if (done) begin
        seen = 1;
        start = noise;
        break;
      end
      if (noise) begin
        start = $urandom_range(0, 1);
        op    = $urandom_range(0, 1);
        src_a = $urandom;
        src_b = $urandom;
      end
      @(posedge clk); #1;
    end
    if (!seen) $display("FAIL run_op_timeout op=%0d a=%h b=%h: done never seen in 100 cycles", o, a, b);
    @(posedge clk); #1;
    start = 1'b0;
    post_done = done;
    post_busy = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 1'b0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if ({busy, done, alu_own, div0} !== 4'b0000)
      $display("FAIL reset_ctl got busy/done/own/div0=%b want 0000", {busy, done, alu_own, div0});
    else pass_cnt++;
    chk_cnt++;
    if ({hi, lo} !== 64'd0) $display("FAIL reset_hilo got %h want 0", {hi, lo});
    else pass_cnt++;
    chk_cnt++;
    if ({alu_a, alu_b, alu_signal} !== {64'd0, 3'b010})
      $display("FAIL reset_alu got a=%h b=%h sig=%b want 0 0 010", alu_a, alu_b, alu_signal);
    else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul_basic();
    int lat, own; logic [2:0] sig; logic pd, pb;
    run_op(1'b0, 32'd7, 32'd6, 0, lat, own, sig, pd, pb);
    chk_cnt++;
    if (lat !== 33) $display("FAIL mul7x6_latency got %0d want 33", lat); else pass_cnt++;
    chk_cnt++;
    if (own !== 32) $display("FAIL mul7x6_alu_own got %0d cycles want 32", own); else pass_cnt++;
    chk_cnt++;
    if (sig !== 3'b010) $display("FAIL mul7x6_alu_signal got %b want 010", sig); else pass_cnt++;
    chk_cnt++;
    if ({hi, lo} !== 64'd42) $display("FAIL mul7x6_hilo got %h want %h", {hi, lo}, 64'd42); else pass_cnt++;
    chk_cnt++;
    if ({pd, pb} !== 2'b00) $display("FAIL mul7x6_done_pulse got done/busy after=%b want 00", {pd, pb});
    else pass_cnt++;
  endtask

  task automatic test_mul_corners();
    int lat, own; logic [2:0] sig; logic pd, pb;
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, own, sig, pd, pb);
    chk_cnt++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001)
      $display("FAIL mul_max_hilo got %h want FFFFFFFE00000001", {hi, lo});
    else pass_cnt++;
    run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 0, lat, own, sig, pd, pb);
    chk_cnt++;
    if ({hi, lo} !== 64'h0000_0001_0000_0000)
      $display("FAIL mul_2p16_hilo got %h want 0000000100000000", {hi, lo});
    else pass_cnt++;
  endtask

  task automatic test_div_directed();
    int lat, own; logic [2:0] sig; logic pd, pb;
    run_op(1'b1, 32'd100, 32'd7, 0, lat, own, sig, pd, pb);
    chk_cnt++;
    if ({hi, lo, div0} !== {32'd2, 32'd14, 1'b0})
      $display("FAIL div100_7 got hi=%h lo=%h div0=%b want 2 14 0", hi, lo, div0);
    else pass_cnt++;
    chk_cnt++;
    if (sig !== 3'b011) $display("FAIL div_alu_signal got %b want 011", sig); else pass_cnt++;
    chk_cnt++;
    if (lat !== 33) $display("FAIL div_latency got %0d want 33", lat); else pass_cnt++;
    run_op(1'b1, 32'hFFFF_FFFF, 32'd1, 0, lat, own, sig, pd, pb);
    chk_cnt++;
    if ({hi, lo} !== {32'd0, 32'hFFFF_FFFF})
      $display("FAIL div_max_1 got hi=%h lo=%h want 0 FFFFFFFF", hi, lo);
    else pass_cnt++;
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, own, sig, pd, pb);
    chk_cnt++;
    if ({hi, lo} !== {32'h8000_0000, 32'd0})
      $display("FAIL div_8000_ffff got hi=%h lo=%h want 80000000 0", hi, lo);
    else pass_cnt++;
  endtask

  task automatic test_div0();
    int lat, own; logic [2:0] sig; logic pd, pb;
    run_op(1'b1, 32'd1234, 32'd0, 0, lat, own, sig, pd, pb);
    chk_cnt++;
    if (lat !== 1) $display("FAIL div0_latency got %0d want 1", lat); else pass_cnt++;
    chk_cnt++;
    if (own !== 0) $display("FAIL div0_alu_own got %0d cycles want 0", own); else pass_cnt++;
    chk_cnt++;
    if ({hi, lo, div0} !== {32'd1234, 32'hFFFF_FFFF, 1'b1})
      $display("FAIL div0_result got hi=%h lo=%h div0=%b want 4d2 FFFFFFFF 1", hi, lo, div0);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if (div0 !== 1'b1) $display("FAIL div0_sticky got %b want 1", div0); else pass_cnt++;
    run_op(1'b0, 32'd2, 32'd3, 0, lat, own, sig, pd, pb);
    chk_cnt++;
    if ({div0, lo} !== {1'b0, 32'd6}) $display("FAIL div0_clear got div0=%b lo=%h want 0 6", div0, lo);
    else pass_cnt++;
  endtask

  task automatic test_ignore_start();
    int lat, own; logic [2:0] sig; logic pd, pb;
    logic [63:0] exp;
    exp = ref_hilo(1'b0, 32'd12345, 32'd6789);
    run_op(1'b0, 32'd12345, 32'd6789, 1, lat, own, sig, pd, pb);
    chk_cnt++;
    if (lat !== 33) $display("FAIL ignore_latency got %0d want 33", lat); else pass_cnt++;
    chk_cnt++;
    if ({hi, lo} !== exp) $display("FAIL ignore_hilo got %h want %h", {hi, lo}, exp); else pass_cnt++;
    chk_cnt++;
    if (pb !== 1'b0) $display("FAIL ignore_done_start got busy=%b want 0", pb); else pass_cnt++;
    exp = ref_hilo(1'b1, 32'hDEAD_BEEF, 32'd977);
    run_op(1'b1, 32'hDEAD_BEEF, 32'd977, 1, lat, own, sig, pd, pb);
    chk_cnt++;
    if ({hi, lo} !== exp) $display("FAIL ignore_div_hilo got %h want %h", {hi, lo}, exp); else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    int lat, own; logic [2:0] sig; logic pd, pb;
    start = 1'b1; op = 1'b0; src_a = 32'hFFFF_0001; src_b = 32'h1234_5677;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_cnt++;
    if ({busy, done, alu_own} !== 3'b000)
      $display("FAIL midrst_ctl got busy/done/own=%b want 000", {busy, done, alu_own});
    else pass_cnt++;
    chk_cnt++;
    if ({hi, lo} !== 64'd0) $display("FAIL midrst_hilo got %h want 0", {hi, lo}); else pass_cnt++;
    chk_cnt++;
    if ({alu_a, alu_b, alu_signal} !== {64'd0, 3'b010})
      $display("FAIL midrst_alu got a=%h b=%h sig=%b want 0 0 010", alu_a, alu_b, alu_signal);
    else pass_cnt++;
    run_op(1'b0, 32'd3, 32'd5, 0, lat, own, sig, pd, pb);
    chk_cnt++;
    if ({lat, hi, lo} !== {32'd33, 32'd0, 32'd15})
      $display("FAIL midrst_mul3x5 got lat=%0d hi=%h lo=%h want 33 0 f", lat, hi, lo);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int lat, own; logic [2:0] sig; logic pd, pb;
    logic o; logic [31:0] a, b; logic [63:0] exp; int exp_lat;
    for (int i = 0; i < 30; i++) begin
      o = $urandom_range(0, 1);
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'($urandom_range(0, 15));
        1:       b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      exp     = ref_hilo(o, a, b);
      exp_lat = (o && b == 32'd0) ? 1 : 33;
      run_op(o, a, b, 0, lat, own, sig, pd, pb);
      chk_cnt++;
      if ({hi, lo} !== exp)
        $display("FAIL rand_hilo[%0d] op=%0d a=%h b=%h got %h want %h", i, o, a, b, {hi, lo}, exp);
      else pass_cnt++;
      chk_cnt++;
      if (lat !== exp_lat) $display("FAIL rand_latency[%0d] got %0d want %0d", i, lat, exp_lat);
      else pass_cnt++;
      chk_cnt++;
      if (div0 !== (o && b == 32'd0)) $display("FAIL rand_div0[%0d] got %b want %b", i, div0, (o && b == 32'd0));
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_mul_corners();
    test_div_directed();
    test_div0();
    test_ignore_start();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
